// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes and lock FSM states shared by the scanner, lock and display stages.
package keypad_pkg;
    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_STAR = 5'd14;
    localparam logic [4:0] KEY_HASH = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd16;
    typedef enum logic [1:0] {ST_ENTRY, ST_UNLOCKED, ST_NEWCODE, ST_LOCKOUT} state_e;
endpackage

// File: rtl/keypad_event.sv
// keypad_event: turns raw scanner samples into one key event per stable press,
// re-arming only after the keypad has been stably released.
module keypad_event
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] number,
    input  logic       pressed,
    output logic       key_valid,
    output logic [3:0] key_code
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);
    logic          wait_q, wait_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    last_q, last_d;
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic          qual;
    assign qual = pressed && (number < KEY_NONE);
    // cnt counts consecutive matching samples, so a count of zero means no run in progress
    always_comb begin
        wait_d  = wait_q;
        cnt_d   = '0;
        last_d  = number;
        valid_d = 1'b0;
        code_d  = code_q;
        if (wait_q) begin
            cnt_d  = pressed ? '0 : cnt_q + 1'b1;
            wait_d = cnt_d != STABLE;
            cnt_d  = (cnt_d == STABLE) ? '0 : cnt_d;
        end else if (qual) begin
            cnt_d = (cnt_q != '0 && number == last_q) ? cnt_q + 1'b1 : CW'(1);
            if (cnt_d == STABLE) begin
                valid_d = 1'b1;
                code_d  = number[3:0];
                wait_d  = 1'b1;
                cnt_d   = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= KEY_NONE;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end
    assign key_valid = valid_q;
    assign key_code  = code_q;
endmodule

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: keypad lock - debounced key events drive a BCD entry buffer,
// code comparison, code change and a timed lockout after repeated failures.
module keypad_code_entry
    import keypad_pkg::*;
#(
    parameter int                    DIGITS         = 4,
    parameter int                    STABLE_CYCLES  = 500000,
    parameter logic [4*DIGITS-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    LOCKOUT_CYCLES = 250000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          number,
    input  logic                pressed,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic [4*DIGITS-1:0] digits_bcd,
    output logic [2:0]          digit_count,
    output logic                unlocked,
    output logic                error,
    output logic                saved,
    output logic                locked_out
);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [2:0]    FULL      = 3'(DIGITS);
    localparam logic [FW-1:0] MAXF      = FW'(MAX_TRIES);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] entry_q, entry_d, stored_q, stored_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [FW-1:0]       fail_q, fail_d;
    logic [LW-1:0]       lock_q, lock_d;
    logic                error_q, error_d, saved_q, saved_d;
    logic                is_digit, is_star, is_hash, is_a, full;
    keypad_event #(.STABLE_CYCLES(STABLE_CYCLES)) u_event (
        .clk       (clk),
        .rst       (rst),
        .number    (number),
        .pressed   (pressed),
        .key_valid (key_valid),
        .key_code  (key_code)
    );
    assign is_digit = key_code < 4'd10;
    assign is_star  = {1'b0, key_code} == KEY_STAR;
    assign is_hash  = {1'b0, key_code} == KEY_HASH;
    assign is_a     = {1'b0, key_code} == KEY_A;
    assign full     = cnt_q == FULL;
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        stored_d = stored_q;
        fail_d   = fail_q;
        lock_d   = '0;
        error_d  = 1'b0;
        saved_d  = 1'b0;
        case (state_q)
            ST_ENTRY, ST_NEWCODE: begin
                if (key_valid && is_digit && !full) begin
                    entry_d = {entry_q[4*DIGITS-5:0], key_code};
                    cnt_d   = cnt_q + 3'd1;
                end else if (key_valid && (is_star || is_hash)) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end
                // ENTRY checks the code; NEWCODE stores it
                if (key_valid && is_hash && state_q == ST_ENTRY) begin
                    if (full && entry_q == stored_q) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = '0;
                    end else begin
                        error_d = 1'b1;
                        fail_d  = (fail_q == MAXF) ? fail_q : fail_q + 1'b1;
                        state_d = (fail_d == MAXF) ? ST_LOCKOUT : ST_ENTRY;
                    end
                end else if (key_valid && is_hash) begin
                    stored_d = full ? entry_q : stored_q;
                    saved_d  = full;
                    error_d  = !full;
                    state_d  = full ? ST_UNLOCKED : ST_NEWCODE;
                end
            end
            ST_UNLOCKED: begin
                state_d = (key_valid && is_hash) ? ST_ENTRY :
                          (key_valid && is_a) ? ST_NEWCODE : ST_UNLOCKED;
                entry_d = '0;
                cnt_d   = '0;
            end
            ST_LOCKOUT: begin
                lock_d = lock_q + 1'b1;
                if (lock_q == LOCK_LAST) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                    entry_d = '0;
                    cnt_d   = '0;
                    lock_d  = '0;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ENTRY;
            entry_q  <= '0;
            cnt_q    <= '0;
            stored_q <= DEFAULT_CODE;
            fail_q   <= '0;
            lock_q   <= '0;
            error_q  <= 1'b0;
            saved_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            stored_q <= stored_d;
            fail_q   <= fail_d;
            lock_q   <= lock_d;
            error_q  <= error_d;
            saved_q  <= saved_d;
        end
    end
    assign digits_bcd  = entry_q;
    assign digit_count = cnt_q;
    assign unlocked    = state_q == ST_UNLOCKED || state_q == ST_NEWCODE;
    assign locked_out  = state_q == ST_LOCKOUT;
    assign error       = error_q;
    assign saved       = saved_q;
endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

Consumes the raw key code produced by the keypad column scanner and turns it into a keypad lock. Stability-qualifies each press into exactly one key event, accumulates decimal digits into a BCD entry buffer, and compares the buffer against a stored code. Drives lock status, a digit display bus and error/lockout flags for the 7-segment and LED stages downstream. Key encoding: 0–9 digits, 10–13 = A–D, 14 = `*`, 15 = `#`, 16 = no key.

## Interface
- `DIGITS`, 4: code length in BCD digits.
- `STABLE_CYCLES`, 500000: consecutive identical samples required to accept a press or a release.
- `DEFAULT_CODE`, 16'h1234: code loaded at reset, BCD, `4*DIGITS` bits.
- `MAX_TRIES`, 3: failed submissions before lockout.
- `LOCKOUT_CYCLES`, 250000000: lockout duration.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `number` in 5: scanner key code, 16 = none.
- `pressed` in 1: scanner key-down flag.
- `key_valid` out 1: one-cycle pulse per accepted press.
- `key_code` out 4: accepted key; valid with `key_valid`, held after.
- `digits_bcd` out 4*DIGITS: entry buffer, newest digit in bits [3:0].
- `digit_count` out 3: digits currently in buffer, 0..DIGITS.
- `unlocked` out 1: level, lock open.
- `error` out 1: one-cycle pulse on rejected submission.
- `saved` out 1: one-cycle pulse when a new code is stored.
- `locked_out` out 1: level, lockout active.

## Operation
- Event qualifier: sample qualifies as press when `pressed`=1 and `number`<16. Stability counter counts consecutive cycles with identical qualifying `number`; any change restarts it at 0. On reaching `STABLE_CYCLES`, emit `key_valid`, latch `key_code`, enter wait-release. Wait-release: needs `STABLE_CYCLES` consecutive samples with `pressed`=0; any press sample restarts count. Only then re-arm. A held key never produces a second event.
- FSM states ENTRY, UNLOCKED, NEWCODE, LOCKOUT; reset → ENTRY.
- ENTRY: digit with `digit_count`<DIGITS shifts left into buffer, count+1; digit when full ignored. `*` clears buffer and count. `#`: if count==DIGITS and buffer==stored code → UNLOCKED, fail counter 0; else `error` pulse, fail counter+1, buffer cleared; if fail counter reaches `MAX_TRIES` → LOCKOUT. A–D ignored.
- UNLOCKED: `unlocked`=1. `#` → ENTRY (relock), buffer cleared. `A` → NEWCODE, buffer cleared. Others ignored.
- NEWCODE: `unlocked` stays 1. Digits/`*` as in ENTRY. `#` with count==DIGITS → stored code := buffer, `saved` pulse, buffer cleared, → UNLOCKED. `#` with fewer digits → `error` pulse, buffer cleared, stay.
- LOCKOUT: `locked_out`=1; all events discarded; counter runs `LOCKOUT_CYCLES`, then → ENTRY, fail counter 0, buffer cleared.
- Fail counter saturates; cleared on unlock or lockout exit.

## Timing
- Reset values: `key_valid`, `error`, `saved`, `unlocked`, `locked_out` = 0; `key_code` = 0; `digits_bcd` = 0; `digit_count` = 0; stored code = `DEFAULT_CODE`; qualifier armed with count 0.
- `key_valid` asserts the cycle after the `STABLE_CYCLES`-th consecutive identical qualifying sample.
- FSM consumes `key_valid` on the same edge it is sampled: buffer, count, state, `error`, `saved` update one cycle after `key_valid`.
- `unlocked`/`locked_out` change in that same cycle.
- `rst` mid-debounce or mid-lockout: everything returns to reset values next cycle, stored code included.
- `number` change during wait-release does not shorten or generate events.

## Structure
- Package `keypad_pkg`: key constants `KEY_A`=10..`KEY_D`=13, `KEY_STAR`=14, `KEY_HASH`=15, `KEY_NONE`=16; FSM state enum; shared by scanner and display stages.
- Sub-module `keypad_event`: stability qualifier (inputs `number`, `pressed`; outputs `key_valid`, `key_code`), parameterised by `STABLE_CYCLES`.
- Top holds FSM, buffer, stored code, fail and lockout counters.

## Test plan
(Bench uses `STABLE_CYCLES`=4, `LOCKOUT_CYCLES`=20.)
- Hold key 5 for 10 cycles, release 4 → exactly one `key_valid`, `key_code`=5; glitch to 6 at cycle 2 restarts count.
- Enter 1,2,3,4,`#` → `unlocked`=1 one cycle after `#` event, `digits_bcd`=0, `digit_count`=0.
- Enter 1,2,3,5,6,`#` → 6 ignored, `digits_bcd`=16'h1235 before `#`, `error` pulse, stays locked.
- Three wrong submissions → `locked_out`=1; keys ignored for 20 cycles; then ENTRY, `locked_out`=0.
- Unlocked, `A`,9,8,7,6,`#` → `saved` pulse; `#` relocks; 9,8,7,6,`#` unlocks; 1,2,3,4,`#` errors.
- Assert `rst` during NEWCODE after 2 digits → all outputs reset, code back to 16'h1234.
